conv_max_pool: RTL and testbench

2x2 max-pooling stage between the convolution datapath and the neural-net controller's pooled-pixel input. Per frame it takes a raster-ordered stream of convolution results, one byte per kernel per accepted cycle. It reduces each kernel's MAP_H x MAP_W feature map to (MAP_H/2) x (MAP_W/2) maxima. It holds the pooled array stable with a valid flag until the controller acknowledges it.

---
 rtl/conv_max_pool.sv | 133 +++++++++++++
 tb/tb_conv_max_pool.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conv_max_pool.sv
// 2x2 max-pooling stage: folds a raster stream of per-kernel samples into pooled maxima,
// then holds the result with pool_valid until the consumer acknowledges it.
module conv_max_pool #(
  parameter int unsigned NUM_KERNELS = 2,
  parameter int unsigned MAP_W       = 4,
  parameter int unsigned MAP_H       = 4,
  parameter int unsigned DATA_W      = 8,
  localparam int unsigned POOL_N     = (MAP_W / 2) * (MAP_H / 2)
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic                                         i_start,
  input  logic                                         i_conv_valid,
  input  logic [NUM_KERNELS-1:0][DATA_W-1:0]           i_conv_data,
  output logic                                         o_conv_ready,
  output logic [NUM_KERNELS-1:0][POOL_N-1:0][DATA_W-1:0] o_pooled,
  output logic                                         o_pool_valid,
  input  logic                                         i_pool_ack,
  output logic                                         o_overflow
);

  localparam int unsigned CW = $clog2(MAP_W);
  localparam int unsigned RW = $clog2(MAP_H);
  localparam int unsigned HW = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;
  localparam int unsigned PW = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  typedef enum logic [1:0] {StIdle, StCollect, StFull} state_e;

  state_e                 r_state, w_state_next;
  logic [CW-1:0]          r_col, w_col_next;
  logic [RW-1:0]          r_row, w_row_next;
  logic                   r_overflow, w_overflow_next;
  logic                   w_accept;
  logic [HW-1:0]          w_half;
  logic [PW-1:0]          w_pidx;

  logic [NUM_KERNELS-1:0][DATA_W-1:0]             r_h;
  logic [DATA_W-1:0]                              r_rowbuf [NUM_KERNELS][MAP_W/2];
  logic [NUM_KERNELS-1:0][POOL_N-1:0][DATA_W-1:0] r_pooled;

  function automatic logic [DATA_W-1:0] max_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  always_comb begin
    w_state_next    = r_state;
    w_col_next      = r_col;
    w_row_next      = r_row;
    w_overflow_next = r_overflow;
    w_accept        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next    = StCollect;
          w_col_next      = '0;
          w_row_next      = '0;
          w_overflow_next = 1'b0;
        end
        if (i_conv_valid) w_overflow_next = 1'b1;
      end
      StCollect: begin
        // Restart wins over a coincident sample; the partial frame is discarded.
        if (i_start) begin
          w_col_next      = '0;
          w_row_next      = '0;
          w_overflow_next = 1'b0;
        end else if (i_conv_valid) begin
          w_accept = 1'b1;
          if (r_col == CW'(MAP_W - 1)) begin
            w_col_next = '0;
            if (r_row == RW'(MAP_H - 1)) begin
              w_row_next   = '0;
              w_state_next = StFull;
            end else begin
              w_row_next = r_row + 1'b1;
            end
          end else begin
            w_col_next = r_col + 1'b1;
          end
        end
      end
      StFull: begin
        if (i_pool_ack)   w_state_next    = StIdle;
        if (i_conv_valid) w_overflow_next = 1'b1;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_col      <= '0;
      r_row      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_col      <= w_col_next;
      r_row      <= w_row_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign w_half = HW'(r_col >> 1);
  assign w_pidx = PW'(32'(r_row >> 1) * (MAP_W / 2) + 32'(r_col >> 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h      <= '0;
      r_pooled <= '0;
      for (int k = 0; k < NUM_KERNELS; k++) begin
        for (int j = 0; j < MAP_W / 2; j++) r_rowbuf[k][j] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < NUM_KERNELS; k++) begin
        unique case ({r_row[0], r_col[0]})
          2'b00: r_h[k] <= i_conv_data[k];
          2'b01: r_rowbuf[k][w_half] <= max_f(r_h[k], i_conv_data[k]);
          2'b10: r_h[k] <= max_f(r_rowbuf[k][w_half], i_conv_data[k]);
          2'b11: r_pooled[k][w_pidx] <= max_f(r_h[k], i_conv_data[k]);
          default: ;
        endcase
      end
    end
  end

  assign o_conv_ready = (r_state == StCollect);
  assign o_pool_valid = (r_state == StFull);
  assign o_overflow   = r_overflow;
  assign o_pooled     = r_pooled;

endmodule

// File: tb/tb_conv_max_pool.sv
// Directed self-checking bench for conv_max_pool at default parameters.
module tb_conv_max_pool;

  logic                        i_clk;
  logic                        i_rst_n;
  logic                        i_start;
  logic                        i_conv_valid;
  logic [1:0][7:0]             i_conv_data;
  logic                        o_conv_ready;
  logic [1:0][3:0][7:0]        o_pooled;
  logic                        o_pool_valid;
  logic                        i_pool_ack;
  logic                        o_overflow;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [7:0]  fr0 [16];
  logic [7:0]  fr1 [16];

  localparam logic [63:0] BasicExp    = 64'h05070D0F_0F0D0705;
  localparam logic [63:0] UnsignedExp = 64'h00000080_000000FF;
  localparam logic [63:0] FillExp     = 64'h22222222_22222222;

  conv_max_pool dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_conv_valid (i_conv_valid),
    .i_conv_data  (i_conv_data),
    .o_conv_ready (o_conv_ready),
    .o_pooled     (o_pooled),
    .o_pool_valid (o_pool_valid),
    .i_pool_ack   (i_pool_ack),
    .o_overflow   (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start(input string tag);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq(tag, 64'(o_conv_ready), 64'd1);
  endtask

  task automatic ack(input string tag);
    i_pool_ack = 1'b1;
    tick();
    i_pool_ack = 1'b0;
    check_eq(tag, 64'(o_pool_valid), 64'd0);
  endtask

  task automatic send_frame(input string tag, input bit gap);
    for (int n = 0; n < 16; n++) begin
      if (gap && n > 0) begin
        i_conv_valid = 1'b0;
        i_conv_data  = 16'hAAAA;
        tick();
      end
      i_conv_valid   = 1'b1;
      i_conv_data[0] = fr0[n];
      i_conv_data[1] = fr1[n];
      tick();
      if (n == 14) check_eq({tag, "_pv_early"}, 64'(o_pool_valid), 64'd0);
    end
    i_conv_valid = 1'b0;
    check_eq({tag, "_pv"}, 64'(o_pool_valid), 64'd1);
    check_eq({tag, "_rdy_low"}, 64'(o_conv_ready), 64'd0);
  endtask

  task automatic load_basic();
    for (int n = 0; n < 16; n++) begin
      fr0[n] = 8'(n);
      fr1[n] = 8'(15 - n);
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_conv_valid = 1'b0;
    i_conv_data  = '0;
    i_pool_ack   = 1'b0;
    #12;
    check_eq("rst_pooled", o_pooled, 64'd0);
    check_eq("rst_flags", {61'd0, o_pool_valid, o_conv_ready, o_overflow}, 64'd0);
    i_rst_n = 1'b1;
    tick();

    // Basic frame
    load_basic();
    pulse_start("basic_rdy");
    send_frame("basic", 1'b0);
    check_eq("basic_pooled", o_pooled, BasicExp);
    ack("basic_ack");

    // Gapped stream, garbage on idle cycles must be ignored
    pulse_start("gap_rdy");
    send_frame("gap", 1'b1);
    check_eq("gap_pooled", o_pooled, BasicExp);
    ack("gap_ack");

    // Unsigned compare: 0x80 must win over 0x7F
    for (int n = 0; n < 16; n++) begin
      fr0[n] = 8'h00;
      fr1[n] = 8'h00;
    end
    fr0[0] = 8'h80; fr0[1] = 8'h7F; fr0[4] = 8'h01; fr0[5] = 8'hFF;
    fr1[0] = 8'h80; fr1[1] = 8'h7F; fr1[4] = 8'h01; fr1[5] = 8'h10;
    pulse_start("uns_rdy");
    send_frame("uns", 1'b0);
    check_eq("uns_k0p0", 64'(o_pooled[0][0]), 64'hFF);
    check_eq("uns_k1p0", 64'(o_pooled[1][0]), 64'h80);
    check_eq("uns_pooled", o_pooled, UnsignedExp);
    ack("uns_ack");

    // Restart after 6 samples; start coincides with a valid sample that must be dropped
    pulse_start("rst_frame_rdy");
    for (int n = 0; n < 6; n++) begin
      i_conv_valid = 1'b1;
      i_conv_data  = 16'h9999;
      tick();
    end
    i_start     = 1'b1;
    i_conv_data = 16'hEEEE;
    tick();
    i_start = 1'b0;
    check_eq("restart_rdy", 64'(o_conv_ready), 64'd1);
    for (int n = 0; n < 16; n++) begin
      fr0[n] = 8'h22;
      fr1[n] = 8'h22;
    end
    send_frame("restart", 1'b0);
    check_eq("restart_pooled", o_pooled, FillExp);

    // Overflow in FULL, then start+ack together, then start
    i_conv_valid = 1'b1;
    i_conv_data  = 16'hFFFF;
    tick();
    i_conv_valid = 1'b0;
    check_eq("ovf_set", 64'(o_overflow), 64'd1);
    check_eq("ovf_pooled", o_pooled, FillExp);
    check_eq("ovf_pv", 64'(o_pool_valid), 64'd1);
    i_start    = 1'b1;
    i_pool_ack = 1'b1;
    tick();
    i_start    = 1'b0;
    i_pool_ack = 1'b0;
    check_eq("hs_pv", 64'(o_pool_valid), 64'd0);
    check_eq("hs_idle", 64'(o_conv_ready), 64'd0);
    check_eq("hs_ovf_kept", 64'(o_overflow), 64'd1);
    pulse_start("hs_rdy");
    check_eq("hs_ovf_clr", 64'(o_overflow), 64'd0);

    // Async reset mid-COLLECT, asserted between edges
    for (int n = 0; n < 5; n++) begin
      i_conv_valid = 1'b1;
      i_conv_data  = 16'h5555;
      tick();
    end
    i_conv_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("arst_pooled", o_pooled, 64'd0);
    check_eq("arst_flags", {61'd0, o_pool_valid, o_conv_ready, o_overflow}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    load_basic();
    pulse_start("arst_rdy");
    send_frame("arst", 1'b0);
    check_eq("arst_frame", o_pooled, BasicExp);
    ack("arst_ack");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
